// File: rtl/passthrough_checker.sv
// passthrough_checker
//
// Stimulus/response wrapper around a black-box passthrough. On an accepted
// start it streams NUM_VECTORS pseudo-random words from a 16-bit Fibonacci
// LFSR into the DUT. It compares each DUT response against a copy of the
// same word delayed by LATENCY cycles, then reports the results.
//
// Ports:
//   clock         - rising-edge clock
//   reset         - asynchronous, active-low reset
//   start         - run request; honoured only in IDLE or DONE
//   dut_in        - stimulus word to the DUT (zero outside RUN)
//   dut_out       - DUT response
//   busy          - high in RUN or DRAIN
//   done          - high in DONE until the next accepted start
//   pass          - done with zero mismatches
//   err_count     - mismatch count, saturating at 16'hFFFF
//   first_err_idx - vector index of the first mismatch, 16'hFFFF if none
module passthrough_checker #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned LATENCY     = 0,
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_DRAIN = 2'd2;
  localparam logic [1:0]  ST_DONE  = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  DRAIN_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  // x^16+x^14+x^13+x^11+1, shifting left with the feedback entering bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      idx_q, idx_d;
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic [15:0]      err_count_q, err_count_d;
  logic [15:0]      first_err_q, first_err_d;
  logic [WIDTH-1:0] dut_in_q, dut_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             start_acc_s;
  logic             tap_valid_s;
  logic [WIDTH-1:0] tap_data_s;
  logic [15:0]      tap_idx_s;
  logic             mismatch_s;

  // Sequencing: state transitions, LFSR advance, vector index, drain count.
  always_comb begin
    start_acc_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    idx_d       = idx_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          lfsr_d  = SEED_EFF;
          idx_d   = 16'h0000;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (idx_q == LAST_IDX) begin
          drain_cnt_d = 4'd0;
          if (LATENCY == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          idx_d = idx_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Expected-value tap: either the live stimulus or the end of a delay line.
  generate
    if (LATENCY == 0) begin : g_no_pipe
      // With no DUT latency, the response is compared against the word driven this cycle.
      always_comb begin
        tap_valid_s = (state_q == ST_RUN);
        tap_data_s  = dut_in_q;
        tap_idx_s   = idx_q;
      end
    end else begin : g_pipe
      logic [LATENCY-1:0]            sr_valid_q, sr_valid_d;
      logic [LATENCY-1:0][WIDTH-1:0] sr_data_q, sr_data_d;
      logic [LATENCY-1:0][15:0]      sr_idx_q, sr_idx_d;

      // Push one entry per cycle. Only RUN cycles carry a valid expectation.
      always_comb begin
        sr_data_d[0]  = dut_in_q;
        sr_idx_d[0]   = idx_q;
        sr_valid_d[0] = (state_q == ST_RUN);
        for (int i = 1; i < int'(LATENCY); i++) begin
          sr_data_d[i]  = sr_data_q[i-1];
          sr_idx_d[i]   = sr_idx_q[i-1];
          sr_valid_d[i] = sr_valid_q[i-1];
        end
        if (start_acc_s) begin
          sr_valid_d = {LATENCY{1'b0}};
        end else begin
          sr_valid_d = sr_valid_d;
        end
      end

      // Delay-line registers.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sr_valid_q <= {LATENCY{1'b0}};
          sr_data_q  <= {(LATENCY*WIDTH){1'b0}};
          sr_idx_q   <= {(LATENCY*16){1'b0}};
        end else begin
          sr_valid_q <= sr_valid_d;
          sr_data_q  <= sr_data_d;
          sr_idx_q   <= sr_idx_d;
        end
      end

      // The oldest entry lines up with the current DUT response.
      always_comb begin
        tap_valid_s = sr_valid_q[LATENCY-1];
        tap_data_s  = sr_data_q[LATENCY-1];
        tap_idx_s   = sr_idx_q[LATENCY-1];
      end
    end
  endgenerate

  // Compare, error accounting and registered output values.
  always_comb begin
    mismatch_s  = tap_valid_s && (dut_out != tap_data_s);
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    if (start_acc_s) begin
      err_count_d = 16'h0000;
      first_err_d = 16'hFFFF;
    end else if (mismatch_s) begin
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end else begin
        err_count_d = err_count_q;
      end
      // A zero count means this is the first mismatch of the run.
      if (err_count_q == 16'h0000) begin
        first_err_d = tap_idx_s;
      end else begin
        first_err_d = first_err_q;
      end
    end else begin
      err_count_d = err_count_q;
    end
    // Outputs are computed from next-state values so that they can be registered without adding latency.
    if (state_d == ST_RUN) begin
      dut_in_d = lfsr_d[WIDTH-1:0];
    end else begin
      dut_in_d = {WIDTH{1'b0}};
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_count_d == 16'h0000);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED_EFF;
      idx_q       <= 16'h0000;
      drain_cnt_q <= 4'd0;
      err_count_q <= 16'h0000;
      first_err_q <= 16'hFFFF;
      dut_in_q    <= {WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      drain_cnt_q <= drain_cnt_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      dut_in_q    <= dut_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign dut_in        = dut_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_passthrough_checker.sv
// Bench for passthrough_checker. Five checker instances share a clock and
// reset, and each one wraps a different modelled DUT:
//   0: LATENCY=0, loopback
//   1: LATENCY=3, 3-register delay
//   2: LATENCY=2, same 3-register delay (intentionally wrong latency)
//   3: LATENCY=0, bit 0 stuck at 1
//   4: LATENCY=1, 1-register delay that flips bit 7 of vector 100
module tb_passthrough_checker;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [4:0] start_v = 5'b00000;
  logic [4:0] busy_v, done_v, pass_v;
  logic [4:0][7:0]  din_v;
  logic [4:0][15:0] err_v, first_v;
  logic [7:0] dout0, dout1, dout2, dout3, dout4;
  logic [7:0] d1a, d1b, d1c, d2a, d2b, d2c, d4;

  int cyc = 0;
  int flip_at = -1;
  int n_vec = 0;
  int n_err = 0;

  logic [7:0] vec [256];
  logic [7:0] capt [300];
  int ncapt = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  passthrough_checker #(.WIDTH(8), .LATENCY(0), .NUM_VECTORS(256), .SEED(16'hACE1)) u0 (
    .clock(clock), .reset(reset), .start(start_v[0]), .dut_in(din_v[0]), .dut_out(dout0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]), .first_err_idx(first_v[0]));
  passthrough_checker #(.WIDTH(8), .LATENCY(3), .NUM_VECTORS(256), .SEED(16'hACE1)) u1 (
    .clock(clock), .reset(reset), .start(start_v[1]), .dut_in(din_v[1]), .dut_out(dout1),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]), .first_err_idx(first_v[1]));
  passthrough_checker #(.WIDTH(8), .LATENCY(2), .NUM_VECTORS(256), .SEED(16'hACE1)) u2 (
    .clock(clock), .reset(reset), .start(start_v[2]), .dut_in(din_v[2]), .dut_out(dout2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]), .first_err_idx(first_v[2]));
  passthrough_checker #(.WIDTH(8), .LATENCY(0), .NUM_VECTORS(256), .SEED(16'hACE1)) u3 (
    .clock(clock), .reset(reset), .start(start_v[3]), .dut_in(din_v[3]), .dut_out(dout3),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(err_v[3]), .first_err_idx(first_v[3]));
  passthrough_checker #(.WIDTH(8), .LATENCY(1), .NUM_VECTORS(256), .SEED(16'hACE1)) u4 (
    .clock(clock), .reset(reset), .start(start_v[4]), .dut_in(din_v[4]), .dut_out(dout4),
    .busy(busy_v[4]), .done(done_v[4]), .pass(pass_v[4]), .err_count(err_v[4]), .first_err_idx(first_v[4]));

  // Modelled DUT pipelines.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      d1a <= 8'h00; d1b <= 8'h00; d1c <= 8'h00;
      d2a <= 8'h00; d2b <= 8'h00; d2c <= 8'h00;
      d4  <= 8'h00;
    end else begin
      d1a <= din_v[1]; d1b <= d1a; d1c <= d1b;
      d2a <= din_v[2]; d2b <= d2a; d2c <= d2b;
      d4  <= din_v[4] ^ ((cyc == flip_at) ? 8'h80 : 8'h00);
    end
  end

  assign dout0 = din_v[0];
  assign dout1 = d1c;
  assign dout2 = d2c;
  assign dout3 = din_v[3] | 8'h01;
  assign dout4 = d4;

  typedef struct {
    int inst;
    int hold;
    int extra_at;
    int exp_lat;
    int exp_pass;
    int exp_err;
    int exp_first;
  } vec_t;

  function automatic logic [15:0] model_step(input logic [15:0] q);
    logic fb;
    fb = q[15] ^ q[13] ^ q[12] ^ q[10];
    return {q[14:0], fb};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start instance i and return the number of cycles from the start edge
  // to the first cycle in which done is high. Instance 0's stimulus is captured.
  task automatic run_inst(input int i, input int hold, input int extra_at, output int lat);
    int s;
    s = 0;
    lat = -1;
    ncapt = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clock);
      if (c > 0 && done_v[i]) begin
        lat = cyc - s;
        break;
      end
      if (i == 0 && busy_v[0] && ncapt < 300) begin
        capt[ncapt] = din_v[0];
        ncapt++;
      end
      if (c == 0) begin
        s = cyc;
        if (i == 4) flip_at = cyc + 101;
      end
      start_v[i] = (c < hold) || (extra_at > 0 && c == extra_at);
    end
    start_v[i] = 1'b0;
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout inst%0d: done never rose within 700 cycles", i);
    end
  endtask

  task automatic check_capture(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) if (capt[k] !== vec[k]) bad++;
    check({tag, " capture length"}, ncapt, 256);
    check({tag, " dut_in sequence mismatches"}, bad, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"}, int'(busy_v[0]), 0);
    check({tag, " done"}, int'(done_v[0]), 0);
    check({tag, " pass"}, int'(pass_v[0]), 0);
    check({tag, " err_count"}, int'(err_v[0]), 0);
    check({tag, " first_err_idx"}, int'(first_v[0]), 16'hFFFF);
    check({tag, " dut_in"}, int'(din_v[0]), 0);
  endtask

  initial begin
    vec_t tbl [7];
    logic [15:0] q;
    logic [7:0] prev;
    int err2, err3, first3, lat;

    // Reference stream and expected error figures.
    q = 16'hACE1;
    for (int k = 0; k < 256; k++) begin
      vec[k] = q[7:0];
      q = model_step(q);
    end
    err2 = 0;
    err3 = 0;
    first3 = 16'hFFFF;
    for (int k = 0; k < 256; k++) begin
      prev = (k == 0) ? 8'h00 : vec[k-1];
      if (vec[k] != prev) err2++;
      if (vec[k][0] == 1'b0) begin
        err3++;
        if (first3 == 16'hFFFF) first3 = k;
      end
    end

    tbl[0] = '{0, 1, 0,  257, 1, 0,    16'hFFFF};
    tbl[1] = '{1, 1, 0,  260, 1, 0,    16'hFFFF};
    tbl[2] = '{2, 1, 0,  259, 0, err2, 0};
    tbl[3] = '{3, 1, 0,  257, 0, err3, first3};
    tbl[4] = '{4, 1, 0,  258, 0, 1,    100};
    tbl[5] = '{0, 1, 20, 257, 1, 0,    16'hFFFF};
    tbl[6] = '{0, 3, 0,  257, 1, 0,    16'hFFFF};

    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int t = 0; t < 7; t++) begin
      run_inst(tbl[t].inst, tbl[t].hold, tbl[t].extra_at, lat);
      check($sformatf("v%0d inst%0d done latency", t, tbl[t].inst), lat, tbl[t].exp_lat);
      check($sformatf("v%0d inst%0d pass", t, tbl[t].inst), int'(pass_v[tbl[t].inst]), tbl[t].exp_pass);
      check($sformatf("v%0d inst%0d err_count", t, tbl[t].inst), int'(err_v[tbl[t].inst]), tbl[t].exp_err);
      check($sformatf("v%0d inst%0d first_err_idx", t, tbl[t].inst), int'(first_v[tbl[t].inst]), tbl[t].exp_first);
      if (tbl[t].inst == 0) check_capture($sformatf("v%0d", t));
      if (t == 0) begin
        check("first dut_in", int'(capt[0]), 8'hE1);
        check("second dut_in", int'(capt[1]), 8'hC3);
        check("third dut_in", int'(capt[2]), 8'h87);
        repeat (5) @(negedge clock);
        check("done held in DONE", int'(done_v[0]), 1);
        check("pass held in DONE", int'(pass_v[0]), 1);
      end
    end

    // Reset in the middle of a run.
    @(negedge clock);
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    repeat (49) @(negedge clock);
    check("busy before mid-run reset", int'(busy_v[0]), 1);
    reset = 1'b0;
    #1;
    check_reset_vals("mid-run reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle after reset busy", int'(busy_v[0]), 0);
    check("idle after reset dut_in", int'(din_v[0]), 0);
    run_inst(0, 1, 0, lat);
    check("post-reset done latency", lat, 257);
    check("post-reset pass", int'(pass_v[0]), 1);
    check("post-reset err_count", int'(err_v[0]), 0);
    check_capture("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/passthrough_checker.md
# passthrough_checker

Self-checking stimulus/response stage that sits around a black-box passthrough under test. It drives a deterministic pseudo-random vector stream into the DUT input, compares the DUT output against the delayed copy of the same stream, and reports mismatch count, first failing index and pass/done. It lets bench tops reduce to a start pulse plus a check of `done`/`pass`, and supports DUTs with a fixed pipeline latency.

## Interface
Parameters:
- `WIDTH`, 8: DUT data width; legal range 1..16.
- `LATENCY`, 0: fixed DUT latency in cycles; legal range 0..15. A value of 0 means a combinational passthrough.
- `NUM_VECTORS`, 256: vectors per run; legal range 1..65535.
- `SEED`, 16'hACE1: LFSR seed. A value of 0 is replaced by 16'h0001.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted at 0).
- `start` in 1: one-cycle run request.
- `dut_in` out WIDTH: stimulus to the DUT input.
- `dut_out` in WIDTH: DUT response.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: high in DONE; stays high until the next accepted start.
- `pass` out 1: `done && err_count == 0`.
- `err_count` out 16: number of mismatches; saturates at 16'hFFFF.
- `first_err_idx` out 16: vector index of the first mismatch; 16'hFFFF when there has been none.

## Operation
- FSM states and transitions:
  - IDLE -> RUN on `start`.
  - RUN -> DRAIN after vector NUM_VECTORS-1 is driven, when LATENCY > 0.
  - RUN -> DONE after the last vector, when LATENCY = 0.
  - DRAIN -> DONE after LATENCY cycles.
  - DONE -> RUN on `start`.
- `start` is ignored in RUN and DRAIN.
- Accepting `start` in IDLE or DONE does the following:
  - reloads the LFSR with the seed;
  - clears the vector index, `err_count` and the valid shift register;
  - sets `first_err_idx` to 16'hFFFF;
  - drops `done`.
- Stimulus generator:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1. Bit 0 is fed with `q[15]^q[13]^q[12]^q[10]`, and the register shifts left.
  - `dut_in = lfsr[WIDTH-1:0]` in RUN. The LFSR advances once per RUN cycle.
  - `dut_in = 0` in every other state.
- Expected-value path:
  - A LATENCY-deep shift register holds `{valid, data, index}`.
  - An entry is pushed every cycle: valid=1 in RUN, valid=0 otherwise.
  - When LATENCY=0 the compare uses the current `dut_in` and index directly.
- Compare:
  - A mismatch occurs when the tap is valid and `dut_out != tap.data`.
  - On a mismatch, `err_count` increments unless it is already at 16'hFFFF.
  - On the first mismatch of a run, `first_err_idx` captures `tap.index`.
  - Values of `dut_out` at invalid taps are never compared.
- Bits of `dut_out` above the lowest WIDTH bits do not exist; the compare covers the full WIDTH.

## Timing
- Reset values:
  - state IDLE, `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=16'hFFFF;
  - LFSR=SEED (or 1 if SEED=0);
  - all valid bits 0.
- `start` sampled high at edge T:
  - vector 0 appears on `dut_in` after edge T (cycle T+1);
  - `busy` is high from T+1.
- Vector k is driven during cycle T+1+k. Its response is compared at the end of cycle T+1+k+LATENCY.
- `done` rises in cycle T+1+NUM_VECTORS+LATENCY. `busy` falls in the same cycle.
- `err_count`, `first_err_idx` and `pass` are registered. They are final in the first cycle that `done` is high.
- Reset asserted mid-run forces all reset values asynchronously. After reset is released the block sits in IDLE and needs a new `start`.
- `start` held high for several cycles starts exactly one run. After DONE, a high `start` restarts in the next cycle.

## Test plan
- WIDTH=8, LATENCY=0, `dut_out` wired to `dut_in`, NUM_VECTORS=256, pulse `start` -> `done` rises 257 cycles after the start edge with `pass`=1, `err_count`=0, `first_err_idx`=16'hFFFF. The first three `dut_in` values match the LFSR sequence computed from 16'hACE1.
- LATENCY=3, DUT modelled as a 3-register delay -> `pass`=1, `done` at start+260. With LATENCY=2 against the same DUT -> `err_count` > 0 and `first_err_idx`=0 for the seed's first mismatching vector.
- LATENCY=0, `dut_out = dut_in | 8'h01` (bit 0 stuck at 1) -> `err_count` equals the number of vectors with bit0=0; `first_err_idx` equals the index of the first such vector; `pass`=0.
- LATENCY=1, DUT flips bit 7 only for vector 100 -> `err_count`=1, `first_err_idx`=100.
- Pulse `start` again 20 cycles into RUN -> it is ignored; `done` time is unchanged. A second `start` after DONE gives an identical `dut_in` sequence and the same results.
- Assert reset at RUN cycle 50 for 2 cycles -> all outputs return to their reset values immediately. A new `start` runs the full 256 vectors from vector 0 and ends with `pass`=1.
